// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the MIPS datapath.
// Redirects from ID insert one bubble; a hazard-unit stall freezes all fetch state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pcPlus4;

  // Control signals from ID only mean something while IF/ID holds a real instruction.
  assign redirect = valid_q & (jump | branch_taken);
  assign target   = jump ? {pc4_q[31:28], jump_index, 2'b00}
                         : {branch_target[31:2], 2'b00};
  assign pcPlus4  = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (stall) begin
      // A redirect raised during the stall is re-asserted by the held instruction later.
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d    = target;
      instr_d = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      pc_d    = pcPlus4;
      instr_d = imem_rdata;
      pc4_d   = pcPlus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      count_q <= 32'h0000_0000;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: sequential fetch, stall, branch, jump,
// ignored/deferred redirects, PC wrap and reset during activity.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int checkCount;
  int failCount;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word k (byte address 4k) holds 32'h2000_0000 + k.
  assign imem_rdata = 32'h2000_0000 + {2'b00, imem_addr[31:2]};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] expAddr,
                          input logic [31:0] expInstr, input logic [31:0] expPc4,
                          input logic expValid, input logic [31:0] expCount);
    checkOutput({tag, ".addr"},  imem_addr,            expAddr);
    checkOutput({tag, ".instr"}, ifid_instr,           expInstr);
    checkOutput({tag, ".pc4"},   ifid_pc4,             expPc4);
    checkOutput({tag, ".valid"}, {31'b0, ifid_valid},  {31'b0, expValid});
    checkOutput({tag, ".count"}, fetch_count,          expCount);
  endtask

  // Set inputs, then advance one rising edge and settle 1 time unit past it.
  task automatic applyStimulus(input logic r, input logic s, input logic bt,
                               input logic [31:0] tgt, input logic j,
                               input logic [25:0] idx);
    rst           = r;
    stall         = s;
    branch_taken  = bt;
    branch_target = tgt;
    jump          = j;
    jump_index    = idx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount    = 0;
    failCount     = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_index    = 26'h0;

    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 26'h0);
    checkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("seq0", 32'h4, 32'h2000_0000, 32'h4, 1'b1, 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("seq1", 32'h8, 32'h2000_0001, 32'h8, 1'b1, 32'd2);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 0, 26'h0);
      checkAll("stall", 32'h8, 32'h2000_0001, 32'h8, 1'b1, 32'd2);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("unstall", 32'hC, 32'h2000_0002, 32'hC, 1'b1, 32'd3);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("seq3", 32'h10, 32'h2000_0003, 32'h10, 1'b1, 32'd4);

    applyStimulus(0, 0, 1, 32'h0000_0043, 0, 26'h0);
    checkAll("branch", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("brTarget", 32'h44, 32'h2000_0010, 32'h44, 1'b1, 32'd5);

    applyStimulus(0, 0, 1, 32'h0000_0100, 0, 26'h0);
    checkAll("branch2", 32'h100, 32'h0, 32'h0, 1'b0, 32'd5);
    applyStimulus(0, 0, 1, 32'h0000_0200, 0, 26'h0);
    checkAll("brOnBubble", 32'h104, 32'h2000_0040, 32'h104, 1'b1, 32'd6);

    applyStimulus(0, 1, 1, 32'h0000_0300, 0, 26'h0);
    checkAll("stallBranch", 32'h104, 32'h2000_0040, 32'h104, 1'b1, 32'd6);
    applyStimulus(0, 0, 1, 32'h0000_0300, 0, 26'h0);
    checkAll("deferBranch", 32'h300, 32'h0, 32'h0, 1'b0, 32'd6);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("deferTarget", 32'h304, 32'h2000_00C0, 32'h304, 1'b1, 32'd7);

    applyStimulus(0, 0, 1, 32'h1000_000C, 0, 26'h0);
    checkAll("toHigh", 32'h1000_000C, 32'h0, 32'h0, 1'b0, 32'd7);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("highWord", 32'h1000_0010, 32'h2400_0003, 32'h1000_0010, 1'b1, 32'd8);
    applyStimulus(0, 0, 1, 32'h0000_0080, 1, 26'h000_0100);
    checkAll("jump", 32'h1000_0400, 32'h0, 32'h0, 1'b0, 32'd8);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("jumpTarget", 32'h1000_0404, 32'h2400_0100, 32'h1000_0404, 1'b1, 32'd9);

    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0, 26'h0);
    checkAll("toTop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd9);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("wrap", 32'h0, 32'h5FFF_FFFF, 32'h0, 1'b1, 32'd10);

    applyStimulus(1, 1, 0, 32'h0, 1, 26'h3FF_FFFF);
    checkAll("midReset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0);
    checkAll("postReset", 32'h4, 32'h2000_0000, 32'h4, 1'b1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the MIPS datapath. Sits directly upstream of the decode/control unit.
- Holds the PC and drives the instruction-memory address. Registers the fetched word and PC+4 so decode can take opcode = ifid_instr[31:26].
- Accepts branch (beq/bne resolved in ID) and jump redirects, inserts one bubble on a redirect, and honours stalls from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  32  instruction memory byte address; combinational copy of the PC register
imem_rdata  in  32  instruction word at imem_addr, valid in the same cycle (combinational read)
stall  in  1  hazard unit: hold the PC and IF/ID contents
branch_taken  in  1  ID stage: beq/bne condition met for the instruction in IF/ID
branch_target  in  32  ID stage: branch target byte address; bits [1:0] are ignored and forced to 0
jump  in  1  ID stage: the instruction in IF/ID is j
jump_index  in  26  ID stage: ifid_instr[25:0] of the jump
ifid_instr  out  32  registered instruction for decode
ifid_pc4  out  32  registered PC+4 of ifid_instr
ifid_valid  out  1  ifid_instr is a real instruction, not a bubble
fetch_count  out  32  count of instructions loaded into IF/ID with valid=1

Behaviour:
- Reset (rst=1 at a clock edge): pc<=RESET_PC, ifid_instr<=0, ifid_pc4<=0, ifid_valid<=0, fetch_count<=0.
  - Reset has priority over every other input, including mid-stall and mid-redirect.
- Redirect definition: redirect = ifid_valid & (jump | branch_taken).
  - Redirect inputs are ignored while ifid_valid=0.
- Target selection:
  - jump=1: target = {ifid_pc4[31:28], jump_index, 2'b00}.
  - otherwise: target = {branch_target[31:2], 2'b00}.
  - jump has priority over branch_taken if both are asserted.
- Per-edge priority when rst=0: stall, then redirect, then normal.
  - stall=1: pc, ifid_instr, ifid_pc4, ifid_valid and fetch_count all hold. A simultaneous redirect is ignored; the held ID instruction re-asserts it once the stall drops.
  - redirect (stall=0): pc<=target, ifid_instr<=32'h0000_0000 (NOP), ifid_pc4<=0, ifid_valid<=0, fetch_count holds. The word on imem_rdata is discarded.
  - normal (stall=0, no redirect): ifid_instr<=imem_rdata, ifid_pc4<=pc+4, ifid_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
- Latency:
  - A word is presented to decode one cycle after its address appears on imem_addr.
  - A taken branch or jump costs exactly one bubble cycle.
- Arithmetic: all 32-bit modulo.
  - pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- imem_addr always equals pc, including during reset and stall.
- No X propagation: every register has a defined reset value, and ifid_instr=0 decodes as an R-type NOP.

Test Plan:
- Reset/sequential fetch: RESET_PC=0, memory word k = 32'h2000_0000+k, rst high 2 cycles then low. Required: imem_addr steps 0,4,8,12. ifid_instr is 20000000,20000001,... one cycle later. ifid_pc4 is 4,8,12. ifid_valid=1 from the first post-reset edge. fetch_count=3 after 3 fetches.
- Stall: assert stall for 3 cycles while imem_addr=8. Required: imem_addr stays 8; ifid_instr, ifid_pc4 and fetch_count are frozen. After release, the fetch at 8 completes on the next edge.
- Taken branch: ifid holds beq with ifid_pc4=16, branch_taken=1, branch_target=32'h0000_0043. Required next edge: pc=32'h40, ifid_valid=0, ifid_instr=0, fetch_count unchanged. The following edge loads the word at 0x40 with ifid_pc4=0x44.
- Jump: ifid_pc4=32'h1000_0010, jump=1, jump_index=26'h000_0100, branch_taken=1, branch_target=32'h80. Required: pc=32'h1000_0400 (jump wins) and one bubble.
- Stall+redirect and redirect-on-bubble:
  - branch_taken=1 with stall=1: pc unchanged; redirect is applied on the first edge with stall=0.
  - branch_taken=1 with ifid_valid=0: ignored; pc<=pc+4.
- Wrap and reset mid-operation:
  - pc=32'hFFFF_FFFC, normal fetch: pc becomes 0 and ifid_pc4=0.
  - rst asserted alongside stall and jump: all outputs take reset values; imem_addr=RESET_PC.
